// File: rtl/mac_array_drain_if.sv
// Bundle of the signals between mac_array_drain and its neighbours.
//   acc_in_0..3 : signed per-MAC accumulator results
//   valid_in    : per-lane result strobes (bit i qualifies acc_in_i)
//   flush       : synchronous clear of assembly, FIFO, serialiser and error flag
//   out_*       : element stream towards writeback (valid/ready)
//   fifo_level  : number of whole tiles currently buffered
//   err_overrun : sticky flag, a lane was strobed twice before its tile committed
// The slave modport is the drain block's view; master is the view of whoever
// drives the MAC results and consumes the element stream.
interface mac_array_drain_if #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic signed [ACC_W-1:0] acc_in_0;
    logic signed [ACC_W-1:0] acc_in_1;
    logic signed [ACC_W-1:0] acc_in_2;
    logic signed [ACC_W-1:0] acc_in_3;
    logic [3:0]              valid_in;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic [1:0]              out_lane;
    logic                    out_last;
    logic [LVL_W-1:0]        fifo_level;
    logic                    err_overrun;

    modport slave (
        input  acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, flush, out_ready,
        output out_valid, out_data, out_lane, out_last, fifo_level, err_overrun
    );

    modport master (
        output acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, flush, out_ready,
        input  out_valid, out_data, out_lane, out_last, fifo_level, err_overrun
    );
endinterface

// File: rtl/mac_array_drain.sv
// Drain stage of the 2x2 MAC array.
// Gathers the four lane results (which may arrive in different cycles) into a
// tile, applies optional ReLU plus signed saturation to OUT_W, buffers whole
// tiles in a DEPTH-entry FIFO and streams them out one element per beat.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : mac_array_drain_if.slave (results in, element stream out, status)
// The bus interface must be instantiated with the same ACC_W/OUT_W/DEPTH.
module mac_array_drain #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter bit RELU  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    mac_array_drain_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TILE_W = 4 * OUT_W;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_lane [4];
    logic [TILE_W-1:0]       proc_flat;

    logic [3:0]              seen_reg;
    logic [TILE_W-1:0]       hold_reg;
    logic                    err_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;
    logic [1:0]              lane_reg;
    logic [TILE_W-1:0]       mem [DEPTH];

    logic                    fifo_full;
    logic                    commit;
    logic                    handshake;
    logic                    pop;
    logic [3:0]              seen_base;
    logic [3:0]              accept;
    logic [3:0]              overrun;
    logic [TILE_W-1:0]       head;

    assign acc_lane[0] = bus.acc_in_0;
    assign acc_lane[1] = bus.acc_in_1;
    assign acc_lane[2] = bus.acc_in_2;
    assign acc_lane[3] = bus.acc_in_3;

    // Per-lane ReLU + saturation, purely combinational ahead of the hold registers.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [ACC_W-1:0] relu_val;
            logic [OUT_W-1:0]        sat_val;

            always_comb begin
                relu_val = acc_lane[gi];
                if (RELU && (acc_lane[gi] < 0)) begin
                    relu_val = '0;
                end
                if (relu_val > SAT_MAX) begin
                    sat_val = SAT_MAX[OUT_W-1:0];
                end else if (relu_val < SAT_MIN) begin
                    sat_val = SAT_MIN[OUT_W-1:0];
                end else begin
                    sat_val = relu_val[OUT_W-1:0];
                end
            end

            assign proc_flat[gi*OUT_W +: OUT_W] = sat_val;
        end
    endgenerate

    assign fifo_full = (level_reg == LVL_W'(DEPTH));
    // A full tile that cannot be written stays put; flush wins over commit.
    assign commit    = (seen_reg == 4'hF) && !fifo_full && !bus.flush;
    assign handshake = bus.out_valid && bus.out_ready;
    assign pop       = handshake && (lane_reg == 2'd3) && !bus.flush;

    // Lanes clear on commit, so a strobe on the commit edge lands in the new tile.
    assign seen_base = commit ? 4'h0 : seen_reg;
    assign accept    = bus.valid_in & ~seen_base;
    assign overrun   = bus.valid_in & seen_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_reg   <= '0;
            hold_reg   <= '0;
            err_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            lane_reg   <= '0;
        end else if (bus.flush) begin
            seen_reg   <= '0;
            err_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            lane_reg   <= '0;
        end else begin
            seen_reg <= seen_base | accept;
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    hold_reg[i*OUT_W +: OUT_W] <= proc_flat[i*OUT_W +: OUT_W];
                end
            end
            if (|overrun) begin
                err_reg <= 1'b1;
            end
            if (commit) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (commit && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !commit) begin
                level_reg <= level_reg - 1'b1;
            end
            if (handshake) begin
                lane_reg <= lane_reg + 2'd1;
            end
        end
    end

    // Tile storage; commit is already gated by flush and is idle during reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_reg] <= hold_reg;
        end
    end

    // Head is read combinationally so the beat is presented the cycle after commit.
    assign head            = mem[rd_ptr_reg];
    assign bus.out_valid   = (level_reg != '0);
    assign bus.out_data    = head[32'(lane_reg)*OUT_W +: OUT_W];
    assign bus.out_lane    = lane_reg;
    assign bus.out_last    = (lane_reg == 2'd3);
    assign bus.fifo_level  = level_reg;
    assign bus.err_overrun = err_reg;
endmodule

// File: tb/tb_mac_array_drain.sv
// Directed testbench for mac_array_drain: two instances, RELU=0 (bus) and
// RELU=1 (bus_r), both ACC_W=16, OUT_W=8, DEPTH=4. Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
module tb_mac_array_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mac_array_drain_if #(.ACC_W(16), .OUT_W(8), .DEPTH(4)) bus ();
    mac_array_drain_if #(.ACC_W(16), .OUT_W(8), .DEPTH(4)) bus_r ();

    mac_array_drain #(.ACC_W(16), .OUT_W(8), .DEPTH(4), .RELU(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mac_array_drain #(.ACC_W(16), .OUT_W(8), .DEPTH(4), .RELU(1'b1)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tile(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
        bus.valid_in = v;
        bus.acc_in_0 = 16'(a0);
        bus.acc_in_1 = 16'(a1);
        bus.acc_in_2 = 16'(a2);
        bus.acc_in_3 = 16'(a3);
    endtask

    // Checks one presented beat (on bus or bus_r) and then advances a cycle.
    task automatic beat(input string tag, input bit relu, input logic [7:0] d, input logic [1:0] l);
        logic       v;
        logic [7:0] od;
        logic [1:0] ol;
        logic       ot;
        v  = relu ? bus_r.out_valid : bus.out_valid;
        od = relu ? bus_r.out_data  : bus.out_data;
        ol = relu ? bus_r.out_lane  : bus.out_lane;
        ot = relu ? bus_r.out_last  : bus.out_last;
        check({tag, "_valid"}, 32'(v), 32'd1);
        check({tag, "_data"},  32'(od), 32'(d));
        check({tag, "_lane"},  32'(ol), 32'(l));
        check({tag, "_last"},  32'(ot), 32'(l == 2'd3));
        $display("beat %s: data=%0h lane=%0d", tag, od, ol);
        step();
    endtask

    initial begin
        set_tile(4'h0, 0, 0, 0, 0);
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        bus_r.valid_in  = 4'h0;
        bus_r.acc_in_0  = '0;
        bus_r.acc_in_1  = '0;
        bus_r.acc_in_2  = '0;
        bus_r.acc_in_3  = '0;
        bus_r.flush     = 1'b0;
        bus_r.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(bus.out_valid),   32'd0);
        check("rst_lane",  32'(bus.out_lane),    32'd0);
        check("rst_last",  32'(bus.out_last),    32'd0);
        check("rst_level", 32'(bus.fifo_level),  32'd0);
        check("rst_err",   32'(bus.err_overrun), 32'd0);
        rst = 1'b0;
        step();

        // Single tile with saturation: 100,-5,300,-200 -> 100,-5,127,-128
        set_tile(4'hF, 100, -5, 300, -200);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        check("t1_lat_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("t1_level", 32'(bus.fifo_level), 32'd1);
        beat("t1_b0", 1'b0, 8'd100, 2'd0);
        beat("t1_b1", 1'b0, 8'hFB,  2'd1);
        beat("t1_b2", 1'b0, 8'h7F,  2'd2);
        beat("t1_b3", 1'b0, 8'h80,  2'd3);
        check("t1_end_valid", 32'(bus.out_valid),  32'd0);
        check("t1_end_level", 32'(bus.fifo_level), 32'd0);

        // Staggered lanes 1,2,3,4
        set_tile(4'h1, 1, 0, 0, 0);
        step();
        set_tile(4'h2, 0, 2, 0, 0);
        step();
        set_tile(4'h4, 0, 0, 3, 0);
        step();
        check("st_nocommit", 32'(bus.out_valid), 32'd0);
        set_tile(4'h8, 0, 0, 0, 4);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        check("st_nocommit2", 32'(bus.out_valid), 32'd0);
        step();
        check("st_level", 32'(bus.fifo_level), 32'd1);
        beat("st_b0", 1'b0, 8'd1, 2'd0);
        beat("st_b1", 1'b0, 8'd2, 2'd1);
        beat("st_b2", 1'b0, 8'd3, 2'd2);
        beat("st_b3", 1'b0, 8'd4, 2'd3);
        check("st_err",   32'(bus.err_overrun), 32'd0);
        check("st_level0", 32'(bus.fifo_level), 32'd0);

        // Overrun: lane 0 gets 7 then 9; 7 must be kept
        set_tile(4'h1, 7, 0, 0, 0);
        step();
        set_tile(4'h1, 9, 0, 0, 0);
        step();
        check("ov_err", 32'(bus.err_overrun), 32'd1);
        set_tile(4'hE, 0, 10, 11, 12);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        step();
        beat("ov_b0", 1'b0, 8'd7,  2'd0);
        beat("ov_b1", 1'b0, 8'd10, 2'd1);
        beat("ov_b2", 1'b0, 8'd11, 2'd2);
        beat("ov_b3", 1'b0, 8'd12, 2'd3);
        check("ov_err_sticky", 32'(bus.err_overrun), 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("ov_err_flushed", 32'(bus.err_overrun), 32'd0);

        // Backpressure: five tiles with out_ready=0, tile k lane j = 10k+j+1
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_tile(4'hF, 10*k+1, 10*k+2, 10*k+3, 10*k+4);
            step();
        end
        set_tile(4'h0, 0, 0, 0, 0);
        step();
        check("bp_level", 32'(bus.fifo_level),  32'd4);
        check("bp_err0",  32'(bus.err_overrun), 32'd0);
        set_tile(4'h1, 99, 0, 0, 0);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        check("bp_err1", 32'(bus.err_overrun), 32'd1);
        step();
        check("bp_stall_data", 32'(bus.out_data), 32'd1);
        check("bp_stall_lane", 32'(bus.out_lane), 32'd0);
        step();
        check("bp_stall_data2", 32'(bus.out_data),  32'd1);
        check("bp_stall_lvl",   32'(bus.fifo_level), 32'd4);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                beat($sformatf("bp_t%0d_b%0d", k, j), 1'b0, 8'(10*k+j+1), 2'(j));
            end
        end
        check("bp_end_valid", 32'(bus.out_valid),  32'd0);
        check("bp_end_level", 32'(bus.fifo_level), 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;

        // ReLU instance: -7,0,5,1000 -> 0,0,5,127
        bus_r.valid_in = 4'hF;
        bus_r.acc_in_0 = -16'sd7;
        bus_r.acc_in_1 = 16'sd0;
        bus_r.acc_in_2 = 16'sd5;
        bus_r.acc_in_3 = 16'sd1000;
        step();
        bus_r.valid_in = 4'h0;
        step();
        beat("relu_b0", 1'b1, 8'd0,  2'd0);
        beat("relu_b1", 1'b1, 8'd0,  2'd1);
        beat("relu_b2", 1'b1, 8'd5,  2'd2);
        beat("relu_b3", 1'b1, 8'h7F, 2'd3);

        // Reset mid-tile after the lane-1 beat
        set_tile(4'hF, 5, 6, 7, 8);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        step();
        beat("mr_b0", 1'b0, 8'd5, 2'd0);
        beat("mr_b1", 1'b0, 8'd6, 2'd1);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(bus.out_valid),  32'd0);
        check("mr_level", 32'(bus.fifo_level), 32'd0);
        check("mr_lane",  32'(bus.out_lane),   32'd0);
        step();
        rst = 1'b0;

        // Flush with two tiles buffered
        bus.out_ready = 1'b0;
        set_tile(4'hF, 1, 1, 1, 1);
        step();
        set_tile(4'hF, 2, 2, 2, 2);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        step();
        check("fl_level2", 32'(bus.fifo_level), 32'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fl_valid", 32'(bus.out_valid),  32'd0);
        check("fl_level", 32'(bus.fifo_level), 32'd0);
        bus.out_ready = 1'b1;
        set_tile(4'hF, 21, 22, 23, 24);
        step();
        set_tile(4'h0, 0, 0, 0, 0);
        step();
        beat("fl_b0", 1'b0, 8'd21, 2'd0);
        beat("fl_b1", 1'b0, 8'd22, 2'd1);
        beat("fl_b2", 1'b0, 8'd23, 2'd2);
        beat("fl_b3", 1'b0, 8'd24, 2'd3);
        check("fl_end_level", 32'(bus.fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_array_drain.md
Name: mac_array_drain

Overview:
- Downstream stage of the 2x2 MAC array.
- Collects the four per-MAC accumulator results (acc_out_0..3 with valid_out[3:0]) into one tile; lanes may arrive in different cycles.
- Applies optional ReLU and signed saturation to OUT_W, buffers whole tiles in a small FIFO, and streams them out one element per beat on a valid/ready interface for the writeback stage.

Parameters:
- ACC_W, 16, accumulator width of incoming results (signed)
- OUT_W, 8, output element width (signed, OUT_W <= ACC_W)
- DEPTH, 4, tile FIFO depth in tiles (power of 2, >= 2)
- RELU, 0, 1 = clamp negative results to 0 before saturation

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- acc_in_0  in  ACC_W  signed result, MAC 0
- acc_in_1  in  ACC_W  signed result, MAC 1
- acc_in_2  in  ACC_W  signed result, MAC 2
- acc_in_3  in  ACC_W  signed result, MAC 3
- valid_in  in  4  per-lane result strobe, bit i qualifies acc_in_i
- flush  in  1  synchronous clear of assembly, FIFO, serialiser, error
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- out_data  out  OUT_W  processed element
- out_lane  out  2  lane index of out_data (0..3)
- out_last  out  1  high on lane-3 beat of a tile
- fifo_level  out  $clog2(DEPTH)+1  tiles stored
- err_overrun  out  1  sticky, a lane strobed twice before its tile committed

Behaviour:
- Reset (async, rst=1): seen[3:0]=0, FIFO empty, lane counter=0, out_valid=0, out_lane=0, out_last=0, fifo_level=0, err_overrun=0. out_data is don't-care while out_valid=0.
- Assembly:
  - Per-lane holding register hold_i and flag seen[i].
  - valid_in[i] & !seen[i]: hold_i <= processed(acc_in_i), seen[i] <= 1.
  - valid_in[i] & seen[i]: value dropped, err_overrun <= 1.
- Processing: x = acc_in; if RELU and x<0 then x = 0; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Purely combinational before hold register.
- Commit: when seen==4'b1111 and FIFO not full, at that edge the tile {hold_3..hold_0} is written and seen <= 0.
  - Same-edge valid_in[i] is accepted into the cleared assembly (seen[i] <= 1, no error).
  - If FIFO full: tile stays in assembly, seen stays 1111; every strobe is an overrun until space frees.
- FIFO: fifo_level increments on commit and decrements on pop; simultaneous commit and pop leaves it unchanged. Pointers wrap modulo DEPTH.
- Serialiser:
  - out_valid = (fifo_level != 0).
  - out_data = head tile lane[lane_cnt]; out_lane = lane_cnt; out_last = (lane_cnt==3).
  - Handshake on out_valid & out_ready: lane_cnt increments; at lane 3 it wraps to 0 and the head is popped.
  - out_data and out_lane hold stable while out_valid & !out_ready.
- Latency: the last lane strobed at edge N gives seen full after N; commit at N+1; out_valid high in the cycle after N+1. Throughput is 1 element/cycle, 4 cycles/tile with out_ready=1.
- flush: next edge clears seen, FIFO, lane_cnt and err_overrun. Takes priority over a same-cycle commit or pop; same-cycle valid_in is ignored.
- rst mid-stream: immediate return to reset state; partially sent tile lost.

Test Plan:
- RELU=0, OUT_W=8, valid_in=1111 once with acc=100,-5,300,-200, out_ready=1 -> out_valid two cycles later; beats 100,-5,127,-128 with lanes 0..3; out_last only on lane 3; fifo_level back to 0.
- Staggered: valid_in=0001,0010,0100,1000 on consecutive cycles, values 1,2,3,4 -> exactly one tile 1,2,3,4; no commit before lane 3; err_overrun=0.
- Overrun: lane 0 strobed twice (7 then 9) before lanes 1..3 arrive -> tile lane 0 = 7, err_overrun=1 until flush.
- Backpressure, DEPTH=4, out_ready=0, five full tiles pushed -> fifo_level=4, fifth held in assembly, sixth strobe sets err_overrun. Then out_ready=1 -> 20 beats in order, fifth tile last; data stable during stall.
- RELU=1 with acc=-7,0,5,1000 -> 0,0,5,127.
- Reset asserted mid-tile (after lane 1 beat), and separately flush with fifo_level=2 -> out_valid=0, fifo_level=0 next cycle; subsequent tile streams correctly from lane 0.
